mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// mem_arbiter : shares one single-ported memory between a data port and an
//               instruction-fetch port, with data priority, instruction
//               anti-starvation and a fixed number of memory wait states.
// Revision    : 1.0
// =============================================================================
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int WAIT_STATES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);

   localparam logic [2:0] WAIT_LAST  = 3'(WAIT_STATES);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic       OWNER_D    = 1'b0;
   localparam logic       OWNER_I    = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_q,   state_d;
   logic [2:0]        wait_q,    wait_d;
   logic [3:0]        starve_q,  starve_d;
   logic              owner_q,   owner_d;
   logic              we_q,      we_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic              w_take_instr;

   // Fetch wins when alone, or when data has already won STARVE_LIMIT times in a row over it
   assign w_take_instr = i_req && (!d_req || (starve_q == STARVE_MAX));

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      starve_d  = starve_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      d_rdata_d = d_rdata_q;
      i_rdata_d = i_rdata_q;

      case (state_q)
         IDLE: begin
            if (d_req || i_req) begin
               state_d = ACCESS;
               wait_d  = 3'd0;
               if (w_take_instr) begin
                  owner_d  = OWNER_I;
                  we_d     = 1'b0;
                  addr_d   = i_addr;
                  starve_d = 4'd0;
               end else begin
                  owner_d  = OWNER_D;
                  we_d     = d_we;
                  addr_d   = d_addr;
                  wdata_d  = d_wdata;
                  starve_d = i_req ? (starve_q + 4'd1) : 4'd0;
               end
            end
         end

         ACCESS: begin
            if (wait_q == WAIT_LAST) begin
               state_d = DONE;
               wait_d  = 3'd0;
               if (owner_q == OWNER_I) begin
                  i_rdata_d = mem_rdata;
               end else if (!we_q) begin
                  d_rdata_d = mem_rdata;
               end
            end else begin
               wait_d = wait_q + 3'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wait_q    <= 3'd0;
         starve_q  <= 4'd0;
         owner_q   <= OWNER_D;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         d_rdata_q <= '0;
         i_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         starve_q  <= starve_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         d_rdata_q <= d_rdata_d;
         i_rdata_q <= i_rdata_d;
      end
   end

   // we_q is only ever set by a data grant, so fetches can never strobe a write
   assign mem_en    = (state_q == ACCESS);
   assign mem_we    = mem_en && (wait_q == 3'd0) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign d_ack     = (state_q == DONE) && (owner_q == OWNER_D);
   assign i_ack     = (state_q == DONE) && (owner_q == OWNER_I);
   assign d_rdata   = d_rdata_q;
   assign i_rdata   = i_rdata_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_arbiter : directed and randomized checks of mem_arbiter against a
//                  transaction-level model of grants, timing and memory.
// Revision       : 1.0
// =============================================================================
module tb_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int WS     = 1;
   localparam int SL     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              d_req, d_we, d_ack, i_req, i_ack;
   logic [ADDR_W-1:0] d_addr, i_addr, mem_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata, i_rdata, mem_wdata, mem_rdata;
   logic              mem_en, mem_we, busy, grant_id;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   // Memory device seen by the DUT; preloaded through a side port during reset
   logic [15:0] env_mem [0:511];
   logic        pre_we;
   logic [8:0]  pre_a;
   logic [15:0] pre_d;

   always @(posedge clk) begin
      if (pre_we) env_mem[pre_a] <= pre_d;
      else if (mem_en && mem_we) env_mem[mem_addr[8:0]] <= mem_wdata;
   end
   assign mem_rdata = env_mem[mem_addr[8:0]];

   // Reference model state
   logic [15:0] ref_mem [0:511];
   int          starve;
   logic [15:0] exp_d, exp_i;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_d_ack"},     32'(d_ack),     32'h0);
      chk({tag, "_i_ack"},     32'(i_ack),     32'h0);
      chk({tag, "_mem_en"},    32'(mem_en),    32'h0);
      chk({tag, "_mem_we"},    32'(mem_we),    32'h0);
      chk({tag, "_busy"},      32'(busy),      32'h0);
      chk({tag, "_grant_id"},  32'(grant_id),  32'h0);
      chk({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
      chk({tag, "_d_rdata"},   32'(d_rdata),   32'h0);
      chk({tag, "_i_rdata"},   32'(i_rdata),   32'h0);
   endtask

   task automatic new_req(input logic port, input logic on);
      if (port) begin
         i_req  = on;
         i_addr = {7'h0, 9'($urandom)};
      end else begin
         d_req   = on;
         d_we    = 1'($urandom);
         d_addr  = {7'h0, 9'($urandom)};
         d_wdata = 16'($urandom);
      end
   endtask

   // One arbitration round, entered and left at a negedge with the FSM idle.
   // scramble: 0 none, 1 randomize winner inputs mid-access, 2 drop winner req.
   // renew: 0 drop winner req after ack, 1 keep it high, 2 random new request.
   task automatic do_round(input int scramble, input int renew,
                           output logic w, output logic g);
      logic [15:0] la, lwd;
      logic        lwe;
      w = 1'b0;
      g = 1'b0;
      chk("idle_busy",   32'(busy),           32'h0);
      chk("idle_mem_en", 32'(mem_en),         32'h0);
      chk("idle_acks",   32'({d_ack, i_ack}), 32'h0);
      if (!d_req && !i_req) begin
         @(posedge clk);
         @(negedge clk);
         return;
      end
      w = i_req && (!d_req || starve == SL);
      if (w) begin
         la = i_addr;  lwe = 1'b0;  lwd = 16'h0;  starve = 0;
      end else begin
         la = d_addr;  lwe = d_we;  lwd = d_wdata;
         starve = i_req ? starve + 1 : 0;
      end
      @(posedge clk);
      for (int k = 1; k <= WS + 1; k++) begin
         @(negedge clk);
         chk("acc_mem_en",   32'(mem_en),           32'h1);
         chk("acc_busy",     32'(busy),             32'h1);
         chk("acc_grant_id", 32'(grant_id),         32'(w));
         chk("acc_mem_addr", 32'(mem_addr),         32'(la));
         chk("acc_mem_we",   32'(mem_we),           32'(k == 1 && lwe));
         chk("acc_acks",     32'({d_ack, i_ack}),   32'h0);
         if (lwe) chk("acc_mem_wdata", 32'(mem_wdata), 32'(lwd));
         if (k == 1 && scramble != 0) begin
            if (w) begin
               i_addr = 16'($urandom);
               i_req  = (scramble == 2) ? 1'b0 : 1'($urandom);
            end else begin
               d_addr  = 16'($urandom);
               d_wdata = 16'($urandom);
               d_we    = 1'($urandom);
               d_req   = (scramble == 2) ? 1'b0 : 1'($urandom);
            end
         end
         @(posedge clk);
      end
      @(negedge clk);
      if (lwe)    ref_mem[la[8:0]] = lwd;
      else if (w) exp_i = ref_mem[la[8:0]];
      else        exp_d = ref_mem[la[8:0]];
      g = grant_id;
      chk("done_d_ack",    32'(d_ack),    32'(!w));
      chk("done_i_ack",    32'(i_ack),    32'(w));
      chk("done_busy",     32'(busy),     32'h1);
      chk("done_mem_en",   32'(mem_en),   32'h0);
      chk("done_mem_we",   32'(mem_we),   32'h0);
      chk("done_d_rdata",  32'(d_rdata),  32'(exp_d));
      chk("done_i_rdata",  32'(i_rdata),  32'(exp_i));
      chk("done_mem_addr", 32'(mem_addr), 32'(la));
      if (renew == 0) begin
         if (w) i_req = 1'b0; else d_req = 1'b0;
      end else if (renew == 1) begin
         if (w) i_req = 1'b1; else d_req = 1'b1;
      end else begin
         new_req(w, 1'($urandom));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic  w, g;
      string pat;
      rst_n = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      i_req = 1'b0; i_addr = '0;
      pre_we = 1'b1; pre_a = '0; pre_d = '0;
      starve = 0; exp_d = 16'h0; exp_i = 16'h0;

      for (int a = 0; a < 512; a++) begin
         @(negedge clk);
         pre_a = 9'(a);
         pre_d = (a == 16) ? 16'hBEEF : (a == 256) ? 16'hA5A5 : 16'($urandom);
         ref_mem[a] = pre_d;
      end
      @(negedge clk);
      pre_we = 1'b0;
      chk_reset("reset");
      rst_n = 1'b1;
      do_round(0, 0, w, g);

      // Data read
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      do_round(0, 0, w, g);
      chk("read_d_rdata", 32'(d_rdata), 32'hBEEF);
      chk("read_i_rdata", 32'(i_rdata), 32'h0);

      // Data write
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
      do_round(0, 0, w, g);
      chk("write_keeps_d_rdata", 32'(d_rdata), 32'hBEEF);

      // Instruction fetch only
      i_req = 1'b1; i_addr = 16'h0100;
      do_round(0, 0, w, g);
      chk("fetch_i_rdata", 32'(i_rdata), 32'hA5A5);

      // Read back the earlier write, dropping the request right after grant
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
      do_round(2, 0, w, g);
      chk("early_drop_rdata", 32'(d_rdata), 32'h1234);
      do_round(0, 0, w, g);
      do_round(0, 0, w, g);

      // Continuous contention
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
      i_req = 1'b1; i_addr = 16'h0140;
      pat = "DDDDIDDDDI";
      for (int n = 0; n < 10; n++) begin
         do_round(0, 1, w, g);
         chk("contention_grant", 32'(g), 32'(pat[n] == "I"));
      end
      do_round(0, 1, w, g);
      do_round(0, 1, w, g);

      // Reset in the second access cycle, with starvation count part-way up
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset("mid_reset");
      d_req = 1'b0; i_req = 1'b0;
      starve = 0; exp_d = 16'h0; exp_i = 16'h0;
      @(negedge clk);
      chk("mid_reset_acks", 32'({d_ack, i_ack}), 32'h0);
      rst_n = 1'b1;
      d_req = 1'b1; i_req = 1'b1;
      pat = "DDDDI";
      for (int n = 0; n < 5; n++) begin
         do_round(0, 1, w, g);
         chk("post_reset_grant", 32'(g), 32'(pat[n] == "I"));
      end
      d_req = 1'b0; i_req = 1'b0;
      do_round(0, 0, w, g);

      // Randomized traffic
      for (int r = 0; r < 300; r++) begin
         if (!d_req && ($urandom % 3 == 0)) new_req(1'b0, 1'b1);
         if (!i_req && ($urandom % 3 == 0)) new_req(1'b1, 1'b1);
         do_round(1, 2, w, g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
